// File: rtl/mm_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mm_load_store_unit_load_align.sv
// Load lane select plus sign/zero extension of a 32-bit read word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import mm_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [2:0]  funct3_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword lane, then extend per access type.
    always_comb begin
        byte_sel = rdata_in[7:0];
        case (offset_in)
            2'd1:    byte_sel = rdata_in[15:8];
            2'd2:    byte_sel = rdata_in[23:16];
            2'd3:    byte_sel = rdata_in[31:24];
            default: byte_sel = rdata_in[7:0];
        endcase
        half_sel = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        case (funct3_in)
            F3_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_out = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_out = {24'd0, byte_sel};
            F3_HU:   data_out = {16'd0, half_sel};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/mm_load_store_unit.sv
// Memory-stage LSU: issues dmem requests from EX/MM fields, formats loads, registers MM/WB fields.
// Latency: non-memory ops 1 cycle; memory ops complete the cycle after resp_valid.
// Backpressure: stall_out holds upstream while a request is pending or unacknowledged.
module mm_load_store_unit
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic [4:0]            rd_in,
    input  logic [2:0]            funct3_in,
    output logic                  stall_out,
    output logic                  dmem_req_valid_out,
    input  logic                  dmem_req_ready_in,
    output logic                  dmem_we_out,
    output logic [DATA_WIDTH-1:0] dmem_addr_out,
    output logic [DATA_WIDTH-1:0] dmem_wdata_out,
    output logic [3:0]            dmem_be_out,
    input  logic                  dmem_resp_valid_in,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_in,
    output logic                  wb_reg_write_out,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    output logic [4:0]            wb_rd_out,
    output logic                  misaligned_out
);

    lsu_state_t            state_q, state_d;
    logic                  req_we_q, req_we_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]            req_be_q, req_be_d;
    logic [1:0]            req_off_q, req_off_d;
    logic [2:0]            req_funct3_q, req_funct3_d;
    logic [4:0]            req_rd_q, req_rd_d;
    logic                  req_reg_write_q, req_reg_write_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  misaligned_q, misaligned_d;

    logic                  access, is_store, misaligned, aligned_access;
    logic [1:0]            offset;
    logic [3:0]            fmt_be;
    logic [DATA_WIDTH-1:0] fmt_wdata, fmt_addr, load_data;

    load_align u_load_align (
        .rdata_in  (dmem_rdata_in),
        .offset_in (req_off_q),
        .funct3_in (req_funct3_q),
        .data_out  (load_data)
    );

    // Decode the incoming access: alignment, byte enables and lane-replicated store data.
    always_comb begin
        access   = mem_read_in | mem_write_in;
        is_store = mem_write_in & ~mem_read_in;
        offset   = alu_result_in[1:0];
        fmt_addr = {alu_result_in[DATA_WIDTH-1:2], 2'b00};
        case (funct3_in[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
        aligned_access = access & ~misaligned;
        case (funct3_in[1:0])
            2'b00: begin
                fmt_be    = 4'b0001 << offset;
                fmt_wdata = {4{write_data_in[7:0]}};
            end
            2'b01: begin
                fmt_be    = 4'b0011 << offset;
                fmt_wdata = {2{write_data_in[15:0]}};
            end
            default: begin
                fmt_be    = 4'b1111;
                fmt_wdata = write_data_in;
            end
        endcase
        if (!is_store) begin
            fmt_be = 4'b1111;
        end
    end

    // Next-state, request latch and writeback field computation.
    always_comb begin
        state_d         = state_q;
        req_we_d        = req_we_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_be_d        = req_be_q;
        req_off_d       = req_off_q;
        req_funct3_d    = req_funct3_q;
        req_rd_d        = req_rd_q;
        req_reg_write_d = req_reg_write_q;
        // Stalled cycles present a bubble to MM/WB.
        wb_reg_write_d  = 1'b0;
        wb_data_d       = wb_data_q;
        wb_rd_d         = wb_rd_q;
        misaligned_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_access) begin
                    req_we_d        = is_store;
                    req_addr_d      = fmt_addr;
                    req_wdata_d     = fmt_wdata;
                    req_be_d        = fmt_be;
                    req_off_d       = offset;
                    req_funct3_d    = funct3_in;
                    req_rd_d        = rd_in;
                    req_reg_write_d = reg_write_in;
                    state_d         = dmem_req_ready_in ? RESP : REQ;
                end else begin
                    // Misaligned accesses retire immediately without touching memory.
                    misaligned_d   = access;
                    wb_reg_write_d = reg_write_in & ~access;
                    wb_data_d      = alu_result_in;
                    wb_rd_d        = rd_in;
                end
            end
            REQ: begin
                if (dmem_req_ready_in) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dmem_resp_valid_in) begin
                    state_d        = IDLE;
                    wb_reg_write_d = req_reg_write_q & ~req_we_q;
                    wb_data_d      = load_data;
                    wb_rd_d        = req_rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request and stall outputs: IDLE forwards the live decode, REQ replays the latch.
    always_comb begin
        if (state_q == IDLE) begin
            dmem_we_out    = is_store;
            dmem_addr_out  = fmt_addr;
            dmem_wdata_out = fmt_wdata;
            dmem_be_out    = fmt_be;
        end else begin
            dmem_we_out    = req_we_q;
            dmem_addr_out  = req_addr_q;
            dmem_wdata_out = req_wdata_q;
            dmem_be_out    = req_be_q;
        end
        dmem_req_valid_out = ~rst & (((state_q == IDLE) & aligned_access) | (state_q == REQ));
        stall_out          = ~rst & (((state_q == IDLE) & aligned_access) | (state_q == REQ) |
                                     ((state_q == RESP) & ~dmem_resp_valid_in));
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_we_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            req_off_q       <= '0;
            req_funct3_q    <= '0;
            req_rd_q        <= '0;
            req_reg_write_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_data_q       <= '0;
            wb_rd_q         <= '0;
            misaligned_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_we_q        <= req_we_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_be_q        <= req_be_d;
            req_off_q       <= req_off_d;
            req_funct3_q    <= req_funct3_d;
            req_rd_q        <= req_rd_d;
            req_reg_write_q <= req_reg_write_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_data_q       <= wb_data_d;
            wb_rd_q         <= wb_rd_d;
            misaligned_q    <= misaligned_d;
        end
    end

    assign wb_reg_write_out = wb_reg_write_q;
    assign wb_data_out      = wb_data_q;
    assign wb_rd_out        = wb_rd_q;
    assign misaligned_out   = misaligned_q;

endmodule

// File: tb/tb_mm_load_store_unit.sv
// Bench for mm_load_store_unit: vector table plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: bench models the memory's ready/response timing directly.
module tb_mm_load_store_unit;
    import mm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_in, mem_read_in, mem_write_in;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        stall_out, dmem_req_valid_out, dmem_req_ready_in, dmem_we_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out;
    logic [3:0]  dmem_be_out;
    logic        dmem_resp_valid_in;
    logic [31:0] dmem_rdata_in;
    logic        wb_reg_write_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_rd_out;
    logic        misaligned_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mm_load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .reg_write_in       (reg_write_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .alu_result_in      (alu_result_in),
        .write_data_in      (write_data_in),
        .rd_in              (rd_in),
        .funct3_in          (funct3_in),
        .stall_out          (stall_out),
        .dmem_req_valid_out (dmem_req_valid_out),
        .dmem_req_ready_in  (dmem_req_ready_in),
        .dmem_we_out        (dmem_we_out),
        .dmem_addr_out      (dmem_addr_out),
        .dmem_wdata_out     (dmem_wdata_out),
        .dmem_be_out        (dmem_be_out),
        .dmem_resp_valid_in (dmem_resp_valid_in),
        .dmem_rdata_in      (dmem_rdata_in),
        .wb_reg_write_out   (wb_reg_write_out),
        .wb_data_out        (wb_data_out),
        .wb_rd_out          (wb_rd_out),
        .misaligned_out     (misaligned_out)
    );

    typedef struct {
        string       name;
        logic        rd_en, wr_en, rw;
        logic [31:0] addr, wdata, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        logic        chk_data;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_in       = 1'b0;
        mem_read_in        = 1'b0;
        mem_write_in       = 1'b0;
        alu_result_in      = 32'd0;
        write_data_in      = 32'd0;
        rd_in              = 5'd0;
        funct3_in          = F3_W;
        dmem_req_ready_in  = 1'b0;
        dmem_resp_valid_in = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s/scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "/wb_reg_write"}, wb_reg_write_out, e.rw);
            chk({tag, "/wb_rd"}, wb_rd_out, e.rd);
            chk({tag, "/misaligned"}, misaligned_out, e.mis);
            if (e.chk_data) chk({tag, "/wb_data"}, wb_data_out, e.data);
        end
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic w, input logic rw,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input logic [4:0] rd, input logic [2:0] f3, input logic mis,
                                input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                                input logic erw, input logic [31:0] ed, input logic cd);
        vec_t v;
        v.name = n; v.rd_en = r; v.wr_en = w; v.rw = rw; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.rd = rd; v.f3 = f3; v.mis = mis; v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd;
        v.e_rw = erw; v.e_data = ed; v.chk_data = cd;
        return v;
    endfunction

    // One access with a zero-wait memory: ready at once, response the following cycle.
    task automatic apply_vec(input vec_t v);
        wb_t e;
        reg_write_in       = v.rw;
        mem_read_in        = v.rd_en;
        mem_write_in       = v.wr_en;
        alu_result_in      = v.addr;
        write_data_in      = v.wdata;
        rd_in              = v.rd;
        funct3_in          = v.f3;
        dmem_req_ready_in  = 1'b1;
        dmem_resp_valid_in = 1'b0;
        e.rw = v.e_rw; e.data = v.e_data; e.rd = v.rd; e.mis = v.mis; e.chk_data = v.chk_data;
        sb.push_back(e);
        #1;
        if (v.mis || !(v.rd_en || v.wr_en)) begin
            chk({v.name, "/req_valid"}, dmem_req_valid_out, 1'b0);
            chk({v.name, "/stall"}, stall_out, 1'b0);
            tick();
            idle();
            pop_check(v.name);
            if (v.mis) begin
                tick();
                chk({v.name, "/misaligned_pulse_end"}, misaligned_out, 1'b0);
            end
        end else begin
            chk({v.name, "/req_valid"}, dmem_req_valid_out, 1'b1);
            chk({v.name, "/stall_c0"}, stall_out, 1'b1);
            chk({v.name, "/addr"}, dmem_addr_out, v.e_addr);
            chk({v.name, "/be"}, dmem_be_out, v.e_be);
            chk({v.name, "/we"}, dmem_we_out, v.wr_en & ~v.rd_en);
            if (v.wr_en && !v.rd_en) chk({v.name, "/wdata"}, dmem_wdata_out, v.e_wdata);
            tick();
            dmem_req_ready_in = 1'b0;
            #1;
            chk({v.name, "/req_valid_resp"}, dmem_req_valid_out, 1'b0);
            chk({v.name, "/stall_c1"}, stall_out, 1'b1);
            dmem_resp_valid_in = 1'b1;
            dmem_rdata_in      = v.rdata;
            #1;
            chk({v.name, "/stall_drop"}, stall_out, 1'b0);
            tick();
            dmem_resp_valid_in = 1'b0;
            pop_check(v.name);
        end
    endtask

    initial begin
        wb_t e;
        idle();
        dmem_rdata_in = 32'd0;

        // Reset: no request while rst is high, wb fields cleared.
        rst           = 1'b1;
        mem_read_in   = 1'b1;
        reg_write_in  = 1'b1;
        alu_result_in = 32'h0000_1000;
        rd_in         = 5'd4;
        #1;
        chk("rst/req_valid", dmem_req_valid_out, 1'b0);
        tick();
        mem_read_in   = 1'b0;
        alu_result_in = 32'h5555_AAAA;
        tick();
        chk("rst/wb_reg_write", wb_reg_write_out, 1'b0);
        chk("rst/wb_data", wb_data_out, 32'd0);
        chk("rst/wb_rd", wb_rd_out, 5'd0);
        chk("rst/misaligned", misaligned_out, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        // name r w rw addr wdata rdata rd f3 mis e_addr e_be e_wdata e_rw e_data chk
        vecs.push_back(mk("pass",    0,0,1, 32'h1234,     0,            0,            5,  F3_W,  0, 0,         4'h0, 0,            1, 32'h1234,     1));
        vecs.push_back(mk("lb",      1,0,1, 32'h1003,     0,            32'h80AABBCC, 7,  F3_B,  0, 32'h1000,  4'hF, 0,            1, 32'hFFFFFF80, 1));
        vecs.push_back(mk("lbu",     1,0,1, 32'h1003,     0,            32'h80AABBCC, 8,  F3_BU, 0, 32'h1000,  4'hF, 0,            1, 32'h00000080, 1));
        vecs.push_back(mk("lb_o1",   1,0,1, 32'h1001,     0,            32'h80AABBCC, 9,  F3_B,  0, 32'h1000,  4'hF, 0,            1, 32'hFFFFFFBB, 1));
        vecs.push_back(mk("lb_o2",   1,0,1, 32'h1002,     0,            32'h017F0000, 10, F3_B,  0, 32'h1000,  4'hF, 0,            1, 32'h0000007F, 1));
        vecs.push_back(mk("lh_o2",   1,0,1, 32'h1002,     0,            32'h80AABBCC, 11, F3_H,  0, 32'h1000,  4'hF, 0,            1, 32'hFFFF80AA, 1));
        vecs.push_back(mk("lhu_o0",  1,0,1, 32'h1000,     0,            32'h1234F678, 12, F3_HU, 0, 32'h1000,  4'hF, 0,            1, 32'h0000F678, 1));
        vecs.push_back(mk("lh_o0",   1,0,1, 32'h1000,     0,            32'h1234F678, 13, F3_H,  0, 32'h1000,  4'hF, 0,            1, 32'hFFFFF678, 1));
        vecs.push_back(mk("lw",      1,0,1, 32'h1004,     0,            32'hCAFEF00D, 14, F3_W,  0, 32'h1004,  4'hF, 0,            1, 32'hCAFEF00D, 1));
        vecs.push_back(mk("rdwr",    1,1,1, 32'h1008,     32'h11111111, 32'h0BADCAFE, 15, F3_W,  0, 32'h1008,  4'hF, 0,            1, 32'h0BADCAFE, 1));
        vecs.push_back(mk("sb_o1",   0,1,1, 32'h2001,     32'h123456A5, 0,            16, F3_B,  0, 32'h2000,  4'h2, 32'hA5A5A5A5, 0, 0,            0));
        vecs.push_back(mk("sw",      0,1,0, 32'h2008,     32'hDEADBEEF, 0,            17, F3_W,  0, 32'h2008,  4'hF, 32'hDEADBEEF, 0, 0,            0));
        vecs.push_back(mk("sh_o0",   0,1,0, 32'h2000,     32'h0000ABCD, 0,            18, F3_H,  0, 32'h2000,  4'h3, 32'hABCDABCD, 0, 0,            0));
        vecs.push_back(mk("sb_o3",   0,1,0, 32'h2003,     32'h000000C3, 0,            19, F3_B,  0, 32'h2000,  4'h8, 32'hC3C3C3C3, 0, 0,            0));
        vecs.push_back(mk("mis_lw",  1,0,1, 32'h3001,     0,            0,            3,  F3_W,  1, 0,         4'h0, 0,            0, 0,            0));
        vecs.push_back(mk("mis_lh",  1,0,1, 32'h3003,     0,            0,            20, F3_H,  1, 0,         4'h0, 0,            0, 0,            0));
        vecs.push_back(mk("mis_lhu", 1,0,1, 32'h3001,     0,            0,            21, F3_HU, 1, 0,         4'h0, 0,            0, 0,            0));
        vecs.push_back(mk("mis_sh",  0,1,0, 32'h3001,     32'h1,        0,            22, F3_H,  1, 0,         4'h0, 0,            0, 0,            0));
        vecs.push_back(mk("mis_sw",  0,1,0, 32'h3002,     32'h1,        0,            23, F3_W,  1, 0,         4'h0, 0,            0, 0,            0));
        vecs.push_back(mk("np_norw", 0,0,0, 32'hFEDC0001, 0,            0,            24, F3_W,  0, 0,         4'h0, 0,            0, 32'hFEDC0001, 1));
        vecs.push_back(mk("lw_b2b",  1,0,1, 32'h100C,     0,            32'h13572468, 25, F3_W,  0, 32'h100C,  4'hF, 0,            1, 32'h13572468, 1));

        foreach (vecs[i]) apply_vec(vecs[i]);
        idle();
        tick();

        // SH with ready held off for 3 cycles; upstream fields are scrambled to show the latch holds.
        reg_write_in  = 1'b1;
        mem_write_in  = 1'b1;
        alu_result_in = 32'h0000_2002;
        write_data_in = 32'hDEAD_BEEF;
        rd_in         = 5'd6;
        funct3_in     = F3_H;
        e.rw = 1'b0; e.data = 32'd0; e.rd = 5'd6; e.mis = 1'b0; e.chk_data = 1'b0;
        sb.push_back(e);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                tick();
                alu_result_in      = 32'hFFFF_FFF0;
                write_data_in      = 32'd0;
                funct3_in          = F3_B;
                dmem_resp_valid_in = (c == 1);
                dmem_req_ready_in  = (c == 3);
                #1;
            end
            chk($sformatf("sh_wait%0d/req_valid", c), dmem_req_valid_out, 1'b1);
            chk($sformatf("sh_wait%0d/stall", c), stall_out, 1'b1);
            chk($sformatf("sh_wait%0d/addr", c), dmem_addr_out, 32'h0000_2000);
            chk($sformatf("sh_wait%0d/be", c), dmem_be_out, 4'b1100);
            chk($sformatf("sh_wait%0d/wdata", c), dmem_wdata_out, 32'hBEEF_BEEF);
            chk($sformatf("sh_wait%0d/we", c), dmem_we_out, 1'b1);
        end
        tick();
        dmem_req_ready_in  = 1'b0;
        dmem_resp_valid_in = 1'b0;
        #1;
        chk("sh_resp/req_valid", dmem_req_valid_out, 1'b0);
        chk("sh_resp/stall", stall_out, 1'b1);
        tick();
        chk("sh_resp2/stall", stall_out, 1'b1);
        dmem_resp_valid_in = 1'b1;
        #1;
        chk("sh_ack/stall", stall_out, 1'b0);
        tick();
        idle();
        pop_check("sh_ack");
        tick();

        // Reset while waiting in RESP: access abandoned, late response ignored.
        reg_write_in      = 1'b1;
        mem_read_in       = 1'b1;
        alu_result_in     = 32'h0000_1000;
        rd_in             = 5'd10;
        funct3_in         = F3_W;
        dmem_req_ready_in = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_resp/req_valid", dmem_req_valid_out, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_resp/stall", stall_out, 1'b0);
        chk("rst_resp/wb_reg_write", wb_reg_write_out, 1'b0);
        dmem_resp_valid_in = 1'b1;
        dmem_rdata_in      = 32'h1111_1111;
        tick();
        dmem_resp_valid_in = 1'b0;
        chk("late_resp/wb_reg_write", wb_reg_write_out, 1'b0);
        chk("late_resp/wb_rd", wb_rd_out, 5'd0);
        chk("late_resp/wb_data", wb_data_out, 32'd0);
        chk("late_resp/stall", stall_out, 1'b0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
